// File: rtl/sat_add_arbiter_if.sv
// Request/response bundle for sat_add_arbiter: two operand requesters on one side,
// one buffered saturated result with N/Z/V flags on the other.
interface sat_add_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a0;
    logic [15:0] req_b0;
    logic        req_sub0;
    logic [15:0] req_a1;
    logic [15:0] req_b1;
    logic        req_sub1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_N;
    logic        rsp_Z;
    logic        rsp_V;

    modport master (
        output req_valid, req_a0, req_b0, req_sub0, req_a1, req_b1, req_sub1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_N, rsp_Z, rsp_V
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_sub0, req_a1, req_b1, req_sub1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_N, rsp_Z, rsp_V
    );
endinterface

// File: rtl/sat_add_arbiter.sv
// Two-requester arbiter in front of one 16-bit saturating add/sub with a one-entry result buffer.
// Define SAT_ADD_ARB_RR_EN for round-robin arbitration; default build is fixed priority (req 0 wins).
module sat_add_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    sat_add_arbiter_if.slave bus,
    output logic [CNT_W-1:0] acc_cnt0,
    output logic [CNT_W-1:0] acc_cnt1
);
    localparam int DATA_W = 16;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_next;

    logic                     full;
    logic                     can_accept;
    logic                     prio;
    logic [1:0]               grant;
    logic [1:0]               acc;
    logic                     acc_any;
    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic                     op_sub;
    logic signed [DATA_W:0]   exact;
    logic signed [DATA_W-1:0] sat_sum;
    logic                     sat_v;

    logic signed [DATA_W-1:0] sum_p1;
    logic                     id_p1;
    logic                     n_p1;
    logic                     z_p1;
    logic                     v_p1;

    // The exact result fits in DATA_W+1 bits; overflow shows as disagreeing top two bits.
    function automatic logic sat_ovf(input logic signed [DATA_W:0] x);
        return x[DATA_W] ^ x[DATA_W-1];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_clamp(input logic signed [DATA_W:0] x);
        if (sat_ovf(x))
            return {x[DATA_W], {(DATA_W-1){~x[DATA_W]}}};
        return x[DATA_W-1:0];
    endfunction

    // Grant favours the priority holder and falls back to it when nobody is valid.
    always_comb begin
        grant = 2'b01;
        if (prio)
            grant = (bus.req_valid[1] | ~bus.req_valid[0]) ? 2'b10 : 2'b01;
        else
            grant = (bus.req_valid[0] | ~bus.req_valid[1]) ? 2'b01 : 2'b10;
    end

    assign bus.req_ready = grant & {2{can_accept}};
    assign acc           = bus.req_valid & bus.req_ready;
    assign acc_any       = |acc;

    always_comb begin
        op_a    = grant[1] ? $signed(bus.req_a1) : $signed(bus.req_a0);
        op_b    = grant[1] ? $signed(bus.req_b1) : $signed(bus.req_b0);
        op_sub  = grant[1] ? bus.req_sub1 : bus.req_sub0;
        exact   = op_sub ? ({op_a[DATA_W-1], op_a} - {op_b[DATA_W-1], op_b})
                         : ({op_a[DATA_W-1], op_a} + {op_b[DATA_W-1], op_b});
        sat_sum = sat_clamp(exact);
        sat_v   = sat_ovf(exact);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (acc_any) state_next = FULL;
            FULL:    if (bus.rsp_ready && !acc_any) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        full       = (state == FULL);
        can_accept = ~full | bus.rsp_ready;
    end

    // ---- stage p1: result buffer, loaded on acceptance, otherwise held ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1 <= '0;
            id_p1  <= 1'b0;
            n_p1   <= 1'b0;
            z_p1   <= 1'b0;
            v_p1   <= 1'b0;
        end else if (acc_any) begin
            sum_p1 <= sat_sum;
            id_p1  <= acc[1];
            n_p1   <= sat_sum[DATA_W-1];
            z_p1   <= (sat_sum == '0);
            v_p1   <= sat_v;
        end
    end

    assign bus.rsp_valid = full;
    assign bus.rsp_id    = id_p1;
    assign bus.rsp_sum   = sum_p1;
    assign bus.rsp_N     = n_p1;
    assign bus.rsp_Z     = z_p1;
    assign bus.rsp_V     = v_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt0 <= '0;
            acc_cnt1 <= '0;
        end else begin
            if (acc[0]) acc_cnt0 <= acc_cnt0 + 1'b1;
            if (acc[1]) acc_cnt1 <= acc_cnt1 + 1'b1;
        end
    end

`ifdef SAT_ADD_ARB_RR_EN
    // Priority passes to the other requester only when someone is accepted.
    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'b0;
        else if (acc_any)
            prio <= ~acc[1];
    end
`else
    assign prio = 1'b0;
`endif

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Directed bench for sat_add_arbiter: reset, saturation, contention, backpressure, reset mid-op, wrap.
module tb_sat_add_arbiter;
    logic       clk;
    logic       rst;
    logic [7:0] acc_cnt0;
    logic [7:0] acc_cnt1;
    int         tests;
    int         failed;
    logic [15:0] last_sum;
    logic        last_id;

    sat_add_arbiter_if bus();

    sat_add_arbiter #(.CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .acc_cnt0 (acc_cnt0),
        .acc_cnt1 (acc_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v,
                           input logic [15:0] a0, input logic [15:0] b0, input logic s0,
                           input logic [15:0] a1, input logic [15:0] b1, input logic s1);
        bus.req_valid = v;
        bus.req_a0 = a0; bus.req_b0 = b0; bus.req_sub0 = s0;
        bus.req_a1 = a1; bus.req_b1 = b1; bus.req_sub1 = s1;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        set_req(2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);

        // Reset then idle
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_valid", bus.rsp_valid, 1'b0);
        check("rst_sum",   bus.rsp_sum, 16'h0000);
        check("rst_flags", {bus.rsp_N, bus.rsp_Z, bus.rsp_V}, 3'b000);
        check("rst_id",    bus.rsp_id, 1'b0);
        check("rst_cnt0",  acc_cnt0, 8'd0);
        check("rst_cnt1",  acc_cnt1, 8'd0);
        check("rst_ready", bus.req_ready, 2'b01);

        // Positive saturation
        set_req(2'b01, 16'h7FF0, 16'h0020, 1'b0, 16'h0, 16'h0, 1'b0);
        #1;
        check("pos_ready", bus.req_ready, 2'b01);
        step();
        bus.req_valid = 2'b00;
        check("pos_valid", bus.rsp_valid, 1'b1);
        check("pos_id",    bus.rsp_id, 1'b0);
        check("pos_sum",   bus.rsp_sum, 16'h7FFF);
        check("pos_NZV",   {bus.rsp_N, bus.rsp_Z, bus.rsp_V}, 3'b001);
        check("pos_cnt0",  acc_cnt0, 8'd1);

        // Negative saturation, then exact zero, back to back with rsp_ready=1
        bus.rsp_ready = 1'b1;
        set_req(2'b10, 16'h0, 16'h0, 1'b0, 16'h8000, 16'h0001, 1'b1);
        #1;
        check("neg_ready", bus.req_ready, 2'b10);
        step();
        check("neg_id",   bus.rsp_id, 1'b1);
        check("neg_sum",  bus.rsp_sum, 16'h8000);
        check("neg_NZV",  {bus.rsp_N, bus.rsp_Z, bus.rsp_V}, 3'b101);
        check("neg_cnt1", acc_cnt1, 8'd1);
        set_req(2'b10, 16'h0, 16'h0, 1'b0, 16'h0005, 16'h0005, 1'b1);
        step();
        check("zero_valid", bus.rsp_valid, 1'b1);
        check("zero_sum",   bus.rsp_sum, 16'h0000);
        check("zero_NZV",   {bus.rsp_N, bus.rsp_Z, bus.rsp_V}, 3'b010);
        check("zero_cnt1",  acc_cnt1, 8'd2);
        bus.req_valid = 2'b00;
        step();
        check("drain_valid", bus.rsp_valid, 1'b0);

        // Contention: req0 -> 100+0, req1 -> 200+0; last accepted was req1 so RR starts at 0
        set_req(2'b11, 16'd100, 16'd0, 1'b0, 16'd200, 16'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
`ifdef SAT_ADD_ARB_RR_EN
            last_id = i[0];
`else
            last_id = 1'b0;
`endif
            last_sum = last_id ? 16'd200 : 16'd100;
            check($sformatf("cont_id%0d", i),  bus.rsp_id, last_id);
            check($sformatf("cont_sum%0d", i), bus.rsp_sum, last_sum);
        end
`ifdef SAT_ADD_ARB_RR_EN
        check("cont_cnt0", acc_cnt0, 8'd4);
        check("cont_cnt1", acc_cnt1, 8'd5);
`else
        check("cont_cnt0", acc_cnt0, 8'd7);
        check("cont_cnt1", acc_cnt1, 8'd2);
`endif

        // Backpressure: buffer full, consumer stalls for 4 cycles while req1 waits
        bus.rsp_ready = 1'b0;
        set_req(2'b10, 16'h0, 16'h0, 1'b0, 16'h1234, 16'h0001, 1'b0);
        #1;
        check("bp_ready0", bus.req_ready, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("bp_ready%0d", i + 1), bus.req_ready, 2'b00);
            check($sformatf("bp_valid%0d", i + 1), bus.rsp_valid, 1'b1);
            check($sformatf("bp_hold%0d", i + 1), {bus.rsp_id, bus.rsp_sum}, {last_id, last_sum});
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_rel_ready", bus.req_ready, 2'b10);
        step();
        bus.req_valid = 2'b00;
        check("bp_new_valid", bus.rsp_valid, 1'b1);
        check("bp_new_id",    bus.rsp_id, 1'b1);
        check("bp_new_sum",   bus.rsp_sum, 16'h1235);
        check("bp_new_NZV",   {bus.rsp_N, bus.rsp_Z, bus.rsp_V}, 3'b000);

        // Reset mid-operation: get acc_cnt0 to 5 with the buffer held full
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(2'b01, 16'h0000, 16'h8000, 1'b1, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        check("mid_cnt0",  acc_cnt0, 8'd5);
        check("mid_valid", bus.rsp_valid, 1'b1);
        check("mid_sum",   bus.rsp_sum, 16'h7FFF);
        check("mid_NZV",   {bus.rsp_N, bus.rsp_Z, bus.rsp_V}, 3'b001);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", bus.rsp_valid, 1'b0);
        check("mid_rst_cnt0",  acc_cnt0, 8'd0);
        check("mid_rst_cnt1",  acc_cnt1, 8'd0);
        check("mid_rst_sum",   bus.rsp_sum, 16'h0000);
        check("mid_rst_ready", bus.req_ready, 2'b01);
        bus.rsp_ready = 1'b1;
        step();
        check("mid_no_ghost", bus.rsp_valid, 1'b0);

        // Counter wrap: 256 accepted ops on requester 0 bring acc_cnt0 back to 0
        set_req(2'b01, 16'h0001, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 255; i++) step();
        check("wrap_cnt0_255", acc_cnt0, 8'd255);
        step();
        bus.req_valid = 2'b00;
        check("wrap_cnt0_0", acc_cnt0, 8'd0);
        check("wrap_sum",    bus.rsp_sum, 16'h0002);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/sat_add_arbiter.md
# sat_add_arbiter

Shares one 16-bit saturating add/subtract datapath between two requesters: requester 0 (ALU execute) and requester 1 (address/PC-offset generation). Each cycle it grants at most one valid request, computes the saturated sum and N/Z/V flags, and holds the registered result in a single-entry output buffer until the consumer accepts it. It sits in the execute stage, in front of the shared adder.

## Interface
- `CNT_W`, default 8: width of the per-requester accepted-operation counters.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  bit i: requester i presents an operation.
- `req_a0`, `req_b0`  in  16  requester 0 operands (signed).
- `req_sub0`  in  1  requester 0: 1 = a−b, 0 = a+b.
- `req_a1`, `req_b1`, `req_sub1`  in  16/16/1  requester 1 equivalents.
- `req_ready`  out  2  bit i: request i is accepted this cycle if `req_valid[i]` is high.
- `rsp_valid`  out  1  the output buffer holds a result.
- `rsp_ready`  in  1  consumer takes the result this cycle.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_sum`  out  16  saturated result.
- `rsp_N`, `rsp_Z`, `rsp_V`  out  1 each  negative, zero and saturation flags.
- `acc_cnt0`, `acc_cnt1`  out  CNT_W  count of accepted operations per requester (wraps).

## Operation
- **Arithmetic.** Exact = sext17(a) + sext17(b), or sext17(a) − sext17(b) when sub=1.
  - Clamp the exact value to [−32768, 32767] to form `rsp_sum`.
  - V = 1 iff clamping occurred. N = `rsp_sum[15]`. Z = (`rsp_sum` == 0).
  - Example: 0x0000 − 0x8000 → 0x7FFF with V=1.
- **States.**
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- **Transitions.**
  - EMPTY→FULL on acceptance.
  - FULL→EMPTY on `rsp_ready` with no acceptance.
  - FULL→FULL on `rsp_ready` with acceptance: the buffer is replaced by the new result.
  - FULL holds with no `rsp_ready`.
- **Can-accept.** can_accept = ~`rsp_valid` | `rsp_ready`.
- **Grant.** Combinational from `req_valid` and the priority state.
  - `req_ready[i]` = grant[i] & can_accept.
  - At most one `req_ready` bit is high in any cycle.
  - `req_ready` must not depend on the requester's own `req_valid` for the granted requester. When neither requester is valid, the grant points at the current priority holder.
- **Acceptance.** Acceptance = `req_valid[i]` & `req_ready[i]`.
  - Operands and `rsp_id` are captured into the buffer at that edge.
  - `acc_cntI` increments at that edge.
- **Stability.** While `rsp_valid`=1 and `rsp_ready`=0, all `rsp_*` outputs are held stable.

## Timing
- **Reset** (takes priority over all other activity, including mid-transaction):
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0x0000.
  - `rsp_N`=0, `rsp_Z`=0, `rsp_V`=0.
  - `acc_cnt0`=`acc_cnt1`=0; priority pointer = requester 0.
  - A buffered result is discarded. `req_ready` = 2'b01 during and after reset, before any request.
- **Latency.** A request accepted at edge t appears with `rsp_valid`=1 in the cycle after edge t, i.e. 1 cycle.
- **Throughput.** One operation per cycle while `rsp_ready` is held at 1.
- **Backpressure.** When FULL and `rsp_ready`=0, `req_ready` = 2'b00.
- **Simultaneous `rsp_ready` and acceptance.** Dequeue and enqueue happen in the same cycle. No bubble, no loss.
- **Counter wrap.** Counters wrap modulo 2^CNT_W with no flag.

## Configuration
- **`SAT_ADD_ARB_RR_EN` defined:** round-robin arbitration.
  - After requester i is accepted, priority passes to requester 1−i.
  - The pointer changes only on acceptance.
- **`SAT_ADD_ARB_RR_EN` undefined:** fixed priority.
  - Requester 0 always wins when valid; requester 1 is granted only when `req_valid[0]`=0.
  - The priority pointer is constant 0.

## Test plan
- **Reset then idle.** Assert `rst` for 2 cycles with no valid requests → `rsp_valid`=0, `rsp_sum`=0, all flags 0, counters 0, `req_ready`=2'b01.
- **Positive saturation.** req0 a=0x7FF0, b=0x0020, sub=0 → next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_sum`=0x7FFF, V=1, N=0, Z=0; `acc_cnt0`=1.
- **Negative saturation and zero.**
  - req1 a=0x8000, b=0x0001, sub=1 → `rsp_sum`=0x8000, V=1, N=1.
  - Then req1 a=0x0005, b=0x0005, sub=1 → `rsp_sum`=0x0000, Z=1, V=0.
- **Contention.** Both requesters valid for 6 cycles with `rsp_ready`=1.
  - With RR_EN: `rsp_id` sequence 0,1,0,1,0,1; counters 3/3.
  - Without RR_EN: all `rsp_id`=0; counters 6/0.
- **Backpressure.** With a result buffered, hold `rsp_ready`=0 for 4 cycles → `req_ready`=00 and `rsp_*` unchanged. Release with req1 valid → dequeue and accept in the same cycle; the new result follows next cycle.
- **Reset mid-operation.** Buffer FULL with `rsp_ready`=0 and `acc_cnt0`=5; assert `rst` for 1 cycle → `rsp_valid`=0, counters 0, and the old result is never presented.
